// File: rtl/reservation_station.sv
// rtl/reservation_station.sv - issue queue with CDB wakeup, stable offer/accept handshake and flush.
// Define RS_OLDEST_FIRST_EN for oldest-ready selection; otherwise the lowest-index ready entry issues.
module reservation_station #(
   parameter int ROBsize    = 32,
   parameter int ROBsizeLog = $clog2(ROBsize+1),
   parameter int DEPTH      = 4
) (
   input  logic                       clk_i,
   input  logic                       reset_i,
   input  logic                       writeEn_i,
   input  logic [ROBsizeLog-1:0]      ROBTag_i,
   input  logic [ROBsizeLog-1:0]      ROBTag1_i,
   input  logic [ROBsizeLog-1:0]      ROBTag2_i,
   input  logic [64:0]                ROBval1_i,
   input  logic [64:0]                ROBval2_i,
   input  logic [9:0]                 commands_i,
   output logic                       stall_o,
   input  logic                       flush_i,
   input  logic                       cdbValid_i,
   input  logic [ROBsizeLog-1:0]      cdbTag_i,
   input  logic [63:0]                cdbData_i,
   output logic                       issueValid_o,
   input  logic                       issueReady_i,
   output logic [ROBsizeLog-1:0]      issueTag_o,
   output logic [63:0]                issueVal1_o,
   output logic [63:0]                issueVal2_o,
   output logic [9:0]                 issueCommands_o,
   output logic [$clog2(DEPTH+1)-1:0] count_o
);
   localparam int TW = ROBsizeLog;
   localparam int IW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   logic [DEPTH-1:0] valid_q, valid_d;
   logic [TW-1:0]    tag_q  [DEPTH];
   logic [TW-1:0]    tag_d  [DEPTH];
   logic [TW-1:0]    tag1_q [DEPTH];
   logic [TW-1:0]    tag1_d [DEPTH];
   logic [TW-1:0]    tag2_q [DEPTH];
   logic [TW-1:0]    tag2_d [DEPTH];
   logic [63:0]      val1_q [DEPTH];
   logic [63:0]      val1_d [DEPTH];
   logic [63:0]      val2_q [DEPTH];
   logic [63:0]      val2_d [DEPTH];
   logic [9:0]       cmd_q  [DEPTH];
   logic [9:0]       cmd_d  [DEPTH];
   logic             hold_q, hold_d;
   logic [IW-1:0]    sel_q, sel_d;
`ifdef RS_OLDEST_FIRST_EN
   logic [IW-1:0]    age_q  [DEPTH];
   logic [IW-1:0]    age_d  [DEPTH];
`endif

   logic [DEPTH-1:0] ready_w;
   logic [CW-1:0]    count_w;
   logic [IW-1:0]    free_idx_w;
   logic [IW-1:0]    pick_idx_w;
   logic             pick_found_w;
   logic [IW-1:0]    sel_idx_w;
   logic             issue_valid_w;
   logic             write_fire_w;
   logic             issue_fire_w;
   logic             cdb_live_w;
   logic             unused_val_msb_w;

   assign unused_val_msb_w = ROBval1_i[64] ^ ROBval2_i[64];

   always_comb begin
      ready_w    = '0;
      count_w    = '0;
      free_idx_w = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         ready_w[i] = valid_q[i] && (tag1_q[i] == '0) && (tag2_q[i] == '0);
         count_w    = count_w + CW'(valid_q[i]);
         if (!valid_q[i]) free_idx_w = i[IW-1:0];
      end
   end

   always_comb begin
      pick_idx_w   = '0;
      pick_found_w = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
`ifdef RS_OLDEST_FIRST_EN
         if (ready_w[i] && (!pick_found_w || age_q[i] < age_q[pick_idx_w])) begin
`else
         if (ready_w[i] && !pick_found_w) begin
`endif
            pick_idx_w   = i[IW-1:0];
            pick_found_w = 1'b1;
         end
      end
   end

   // An unaccepted offer stays pinned so a newly ready entry cannot displace it.
   assign sel_idx_w     = hold_q ? sel_q : pick_idx_w;
   assign issue_valid_w = |ready_w;
   assign stall_o       = (count_w == CW'(DEPTH));
   assign count_o       = count_w;
   assign write_fire_w  = writeEn_i && !stall_o && !flush_i;
   assign issue_fire_w  = issue_valid_w && issueReady_i && !flush_i;
   assign cdb_live_w    = cdbValid_i && (cdbTag_i != '0);

   assign issueValid_o    = issue_valid_w;
   assign issueTag_o      = issue_valid_w ? tag_q[sel_idx_w]  : '0;
   assign issueVal1_o     = issue_valid_w ? val1_q[sel_idx_w] : '0;
   assign issueVal2_o     = issue_valid_w ? val2_q[sel_idx_w] : '0;
   assign issueCommands_o = issue_valid_w ? cmd_q[sel_idx_w]  : '0;

   always_comb begin
      valid_d = valid_q;
      tag_d   = tag_q;
      tag1_d  = tag1_q;
      tag2_d  = tag2_q;
      val1_d  = val1_q;
      val2_d  = val2_q;
      cmd_d   = cmd_q;
      hold_d  = 1'b0;
      sel_d   = '0;
`ifdef RS_OLDEST_FIRST_EN
      age_d   = age_q;
`endif
      if (flush_i) begin
         valid_d = '0;
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] && cdb_live_w && tag1_q[i] == cdbTag_i) begin
               tag1_d[i] = '0;
               val1_d[i] = cdbData_i;
            end
            if (valid_q[i] && cdb_live_w && tag2_q[i] == cdbTag_i) begin
               tag2_d[i] = '0;
               val2_d[i] = cdbData_i;
            end
         end
         if (issue_fire_w) begin
            valid_d[sel_idx_w] = 1'b0;
`ifdef RS_OLDEST_FIRST_EN
            for (int i = 0; i < DEPTH; i++) begin
               if (valid_q[i] && age_q[i] > age_q[sel_idx_w]) age_d[i] = age_q[i] - 1'b1;
            end
`endif
         end
         if (write_fire_w) begin
            valid_d[free_idx_w] = 1'b1;
            tag_d[free_idx_w]   = ROBTag_i;
            cmd_d[free_idx_w]   = commands_i;
            if (cdb_live_w && ROBTag1_i == cdbTag_i) begin
               tag1_d[free_idx_w] = '0;
               val1_d[free_idx_w] = cdbData_i;
            end else begin
               tag1_d[free_idx_w] = ROBTag1_i;
               val1_d[free_idx_w] = ROBval1_i[63:0];
            end
            if (cdb_live_w && ROBTag2_i == cdbTag_i) begin
               tag2_d[free_idx_w] = '0;
               val2_d[free_idx_w] = cdbData_i;
            end else begin
               tag2_d[free_idx_w] = ROBTag2_i;
               val2_d[free_idx_w] = ROBval2_i[63:0];
            end
`ifdef RS_OLDEST_FIRST_EN
            // Rank equals the number of entries that remain older after this edge.
            age_d[free_idx_w] = IW'(count_w - CW'(issue_fire_w));
`endif
         end
         hold_d = issue_valid_w && !issueReady_i;
         sel_d  = sel_idx_w;
      end
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         valid_q <= '0;
         hold_q  <= 1'b0;
         sel_q   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i]  <= '0;
            tag1_q[i] <= '0;
            tag2_q[i] <= '0;
            val1_q[i] <= '0;
            val2_q[i] <= '0;
            cmd_q[i]  <= '0;
`ifdef RS_OLDEST_FIRST_EN
            age_q[i]  <= '0;
`endif
         end
      end else begin
         valid_q <= valid_d;
         hold_q  <= hold_d;
         sel_q   <= sel_d;
         for (int i = 0; i < DEPTH; i++) begin
            tag_q[i]  <= tag_d[i];
            tag1_q[i] <= tag1_d[i];
            tag2_q[i] <= tag2_d[i];
            val1_q[i] <= val1_d[i];
            val2_q[i] <= val2_d[i];
            cmd_q[i]  <= cmd_d[i];
`ifdef RS_OLDEST_FIRST_EN
            age_q[i]  <= age_d[i];
`endif
         end
      end
   end
endmodule

// File: tb/tb_reservation_station.sv
// tb/tb_reservation_station.sv - scoreboard bench for reservation_station against a sequence-number queue model.
module tb_reservation_station;
   localparam int ROBsize = 32;
   localparam int TW      = $clog2(ROBsize+1);
   localparam int DEPTH   = 4;
   localparam int CW      = $clog2(DEPTH+1);

   logic            clk_i = 1'b0;
   logic            reset_i;
   logic            writeEn_i;
   logic [TW-1:0]   ROBTag_i, ROBTag1_i, ROBTag2_i;
   logic [64:0]     ROBval1_i, ROBval2_i;
   logic [9:0]      commands_i;
   logic            stall_o;
   logic            flush_i;
   logic            cdbValid_i;
   logic [TW-1:0]   cdbTag_i;
   logic [63:0]     cdbData_i;
   logic            issueValid_o;
   logic            issueReady_i;
   logic [TW-1:0]   issueTag_o;
   logic [63:0]     issueVal1_o, issueVal2_o;
   logic [9:0]      issueCommands_o;
   logic [CW-1:0]   count_o;

   reservation_station #(.ROBsize(ROBsize), .DEPTH(DEPTH)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .writeEn_i(writeEn_i), .ROBTag_i(ROBTag_i),
      .ROBTag1_i(ROBTag1_i), .ROBTag2_i(ROBTag2_i), .ROBval1_i(ROBval1_i), .ROBval2_i(ROBval2_i),
      .commands_i(commands_i), .stall_o(stall_o), .flush_i(flush_i), .cdbValid_i(cdbValid_i),
      .cdbTag_i(cdbTag_i), .cdbData_i(cdbData_i), .issueValid_o(issueValid_o),
      .issueReady_i(issueReady_i), .issueTag_o(issueTag_o), .issueVal1_o(issueVal1_o),
      .issueVal2_o(issueVal2_o), .issueCommands_o(issueCommands_o), .count_o(count_o));

   always #5 clk_i = ~clk_i;

   typedef struct packed {
      logic          iv;
      logic [TW-1:0] tag;
      logic [63:0]   v1;
      logic [63:0]   v2;
      logic [9:0]    cmd;
      logic          stall;
      logic [CW-1:0] cnt;
   } obs_t;

   obs_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   bit          m_valid [DEPTH];
   logic [TW-1:0] m_tag [DEPTH];
   logic [TW-1:0] m_t1  [DEPTH];
   logic [TW-1:0] m_t2  [DEPTH];
   logic [63:0] m_v1    [DEPTH];
   logic [63:0] m_v2    [DEPTH];
   logic [9:0]  m_cmd   [DEPTH];
   int          m_seq   [DEPTH];
   int          seq_ctr = 0;
   bit          m_hold  = 0;
   int          m_held  = 0;

   function automatic int model_count();
      int n = 0;
      for (int i = 0; i < DEPTH; i++) n += m_valid[i] ? 1 : 0;
      return n;
   endfunction

   function automatic int model_pick();
      int best = -1;
      if (m_hold) return m_held;
      for (int i = 0; i < DEPTH; i++) begin
         if (m_valid[i] && m_t1[i] == 0 && m_t2[i] == 0) begin
`ifdef RS_OLDEST_FIRST_EN
            if (best < 0 || m_seq[i] < m_seq[best]) best = i;
`else
            if (best < 0) best = i;
`endif
         end
      end
      return best;
   endfunction

   task automatic model_clear();
      for (int i = 0; i < DEPTH; i++) m_valid[i] = 0;
      m_hold = 0;
   endtask

   task automatic model_update(input int s, input bit was_full);
      bit pre [DEPTH];
      int w = -1;
      bit cdb = cdbValid_i && cdbTag_i != 0;
      for (int i = 0; i < DEPTH; i++) pre[i] = m_valid[i];
      if (flush_i) begin
         model_clear();
         return;
      end
      for (int i = 0; i < DEPTH; i++) begin
         if (pre[i] && cdb && m_t1[i] == cdbTag_i) begin m_t1[i] = 0; m_v1[i] = cdbData_i; end
         if (pre[i] && cdb && m_t2[i] == cdbTag_i) begin m_t2[i] = 0; m_v2[i] = cdbData_i; end
      end
      if (s >= 0 && issueReady_i) m_valid[s] = 0;
      if (writeEn_i && !was_full) begin
         for (int i = DEPTH - 1; i >= 0; i--) if (!pre[i]) w = i;
         m_valid[w] = 1;
         m_tag[w]   = ROBTag_i;
         m_cmd[w]   = commands_i;
         m_t1[w]    = (cdb && ROBTag1_i == cdbTag_i) ? '0 : ROBTag1_i;
         m_v1[w]    = (cdb && ROBTag1_i == cdbTag_i) ? cdbData_i : ROBval1_i[63:0];
         m_t2[w]    = (cdb && ROBTag2_i == cdbTag_i) ? '0 : ROBTag2_i;
         m_v2[w]    = (cdb && ROBTag2_i == cdbTag_i) ? cdbData_i : ROBval2_i[63:0];
         m_seq[w]   = seq_ctr;
         seq_ctr++;
      end
      m_hold = (s >= 0) && !issueReady_i;
      m_held = s;
   endtask

   task automatic cycle();
      obs_t e = '0;
      int   s = model_pick();
      int   n = model_count();
      if (s >= 0) begin
         e.iv  = 1'b1;
         e.tag = m_tag[s];
         e.v1  = m_v1[s];
         e.v2  = m_v2[s];
         e.cmd = m_cmd[s];
      end
      e.cnt   = CW'(n);
      e.stall = (n == DEPTH);
      exp_q.push_back(e);
      @(posedge clk_i);
      model_update(s, e.stall);
      #1;
   endtask

   always @(negedge clk_i) begin
      obs_t a, e;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         a = {issueValid_o, issueTag_o, issueVal1_o, issueVal2_o, issueCommands_o, stall_o, count_o};
         checks++;
         if (a !== e) begin
            errors++;
            $display("FAIL scoreboard t=%0t got iv=%0b tag=%0d v1=%h v2=%h cmd=%h stall=%0b cnt=%0d exp iv=%0b tag=%0d v1=%h v2=%h cmd=%h stall=%0b cnt=%0d",
                     $time, a.iv, a.tag, a.v1, a.v2, a.cmd, a.stall, a.cnt,
                     e.iv, e.tag, e.v1, e.v2, e.cmd, e.stall, e.cnt);
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", name, act, exp);
      end
   endtask

   task automatic idle();
      writeEn_i  = 0;
      cdbValid_i = 0;
      cdbTag_i   = '0;
      flush_i    = 0;
   endtask

   task automatic wr(input int tag, input int t1, input int t2, input logic [63:0] v1, input logic [63:0] v2);
      writeEn_i  = 1;
      ROBTag_i   = TW'(tag);
      ROBTag1_i  = TW'(t1);
      ROBTag2_i  = TW'(t2);
      ROBval1_i  = {1'($urandom), v1};
      ROBval2_i  = {1'($urandom), v2};
      commands_i = 10'($urandom);
   endtask

   task automatic cdb(input int tag, input logic [63:0] data);
      cdbValid_i = 1;
      cdbTag_i   = TW'(tag);
      cdbData_i  = data;
   endtask

   function automatic logic [63:0] r64();
      return {$urandom, $urandom};
   endfunction

   task automatic randomize_inputs();
      if ($urandom_range(0, 9) < 6) wr($urandom_range(1, 31), $urandom_range(0, 3), $urandom_range(0, 3), r64(), r64());
      else writeEn_i = 0;
      cdbValid_i   = $urandom_range(0, 1);
      cdbTag_i     = TW'($urandom_range(0, 3));
      cdbData_i    = r64();
      issueReady_i = ($urandom_range(0, 9) < 7);
      flush_i      = ($urandom_range(0, 49) == 0);
   endtask

   initial begin
      reset_i = 1; issueReady_i = 0; ROBTag_i = '0; ROBTag1_i = '0; ROBTag2_i = '0;
      ROBval1_i = '0; ROBval2_i = '0; commands_i = '0; cdbData_i = '0;
      idle();
      model_clear();
      repeat (2) @(posedge clk_i);
      #1;
      chk("reset_count", 64'(count_o), 0);
      chk("reset_issue_valid", 64'(issueValid_o), 0);
      chk("reset_stall", 64'(stall_o), 0);
      chk("reset_issue_val1", issueVal1_o, 0);
      reset_i = 0;

      issueReady_i = 1;
      wr(5, 0, 0, 3, 4); cycle(); idle();
      chk("basic_issue_tag", 64'(issueTag_o), 5);
      chk("basic_issue_val1", issueVal1_o, 3);
      chk("basic_issue_val2", issueVal2_o, 4);
      repeat (2) cycle();
      chk("basic_count_drained", 64'(count_o), 0);

      wr(7, 2, 0, r64(), 9); cycle(); idle();
      cdb(2, 64'hAB); cycle(); idle();
      chk("cdb_later_val1", issueVal1_o, 64'hAB);
      repeat (2) cycle();
      wr(7, 2, 0, r64(), 9); cdb(2, 64'hAB); cycle(); idle();
      chk("cdb_bypass_val1", issueVal1_o, 64'hAB);
      repeat (2) cycle();

      issueReady_i = 0;
      repeat (DEPTH + 1) begin wr($urandom_range(1, 31), 0, 0, r64(), r64()); cycle(); end
      chk("full_stall", 64'(stall_o), 1);
      issueReady_i = 1;
      wr(30, 0, 0, r64(), r64()); cycle(); idle();
      chk("full_count_after_free", 64'(count_o), DEPTH - 1);
      repeat (DEPTH + 1) cycle();

      issueReady_i = 0;
      wr(12, 0, 0, r64(), r64()); cycle();
      wr(13, 0, 0, r64(), r64()); cycle(); idle();
      repeat (3) cycle();
      issueReady_i = 1;
      repeat (3) cycle();

      wr(9, 3, 0, r64(), r64()); cycle();
      wr(10, 4, 0, r64(), r64()); cycle(); idle();
      cdb(3, r64()); cycle(); idle();
      cycle();
      wr(11, 4, 0, r64(), r64()); cycle(); idle();
      cdb(4, r64()); cycle(); idle();
`ifdef RS_OLDEST_FIRST_EN
      chk("age_policy_first", 64'(issueTag_o), 10);
`else
      chk("age_policy_first", 64'(issueTag_o), 11);
`endif
      repeat (3) cycle();

      issueReady_i = 0;
      repeat (3) begin wr($urandom_range(1, 31), 0, 0, r64(), r64()); cycle(); end
      idle(); issueReady_i = 1; flush_i = 1; cycle(); idle();
      chk("flush_count", 64'(count_o), 0);
      repeat (2) cycle();

      repeat (1500) begin randomize_inputs(); cycle(); end

      issueReady_i = 0;
      repeat (2) begin wr($urandom_range(1, 31), 0, 0, r64(), r64()); cycle(); end
      idle();
      reset_i = 1;
      #2;
      chk("async_reset_count", 64'(count_o), 0);
      chk("async_reset_issue_valid", 64'(issueValid_o), 0);
      @(posedge clk_i); #1;
      reset_i = 0;
      model_clear();
      repeat (300) begin randomize_inputs(); cycle(); end
      idle(); issueReady_i = 1;
      repeat (DEPTH + 2) cycle();
      @(negedge clk_i); #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
